// File: rtl/multu_sequencer.sv
// Sequences the shared 32-cycle shift-add multiplier through MULTU, OUT and MFLO
// phases, then captures the 64-bit product into the architectural HI/LO registers.
module multu_sequencer #(
  parameter int unsigned CYCLES     = 32,
  parameter logic [5:0]  MULTU_CODE = 6'd25,
  parameter logic [5:0]  OUT_CODE   = 6'd63,
  parameter logic [5:0]  MFLO_CODE  = 6'd18,
  parameter logic [5:0]  NOP_CODE   = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        abort,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic [31:0] mul_dataA,
  output logic [31:0] mul_dataB,
  output logic [5:0]  mul_signal,
  output logic        mul_reset,
  input  logic [63:0] mul_dataOut,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // opA/opB must be valid in that cycle and are not needed afterwards.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_OUT  = 2'd2,
    S_CLR  = 2'd3
  } state_t;

  localparam logic [5:0] LAST_IT = 6'(CYCLES - 1);

  state_t     state;
  logic [5:0] it;
  logic       aborted;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign mul_reset = reset;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      it         <= 6'd0;
      aborted    <= 1'b0;
      mul_dataA  <= 32'd0;
      mul_dataB  <= 32'd0;
      mul_signal <= NOP_CODE;
      hi         <= 32'd0;
      lo         <= 32'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (req_valid) begin
            mul_dataA  <= opA;
            mul_dataB  <= opB;
            it         <= 6'd0;
            aborted    <= 1'b0;
            state      <= S_MUL;
            mul_signal <= MULTU_CODE;
          end
        end
        S_MUL: begin
          it <= it + 6'd1;
          if (abort) begin
            aborted    <= 1'b1;
            state      <= S_CLR;
            mul_signal <= MFLO_CODE;
          end else if (it == LAST_IT) begin
            state      <= S_OUT;
            mul_signal <= OUT_CODE;
          end
        end
        S_OUT: begin
          if (abort) aborted <= 1'b1;
          state      <= S_CLR;
          mul_signal <= MFLO_CODE;
        end
        S_CLR: begin
          // MFLO is driven on both paths so the multiplier's counter always returns to 0.
          if (!aborted) begin
            hi   <= mul_dataOut[63:32];
            lo   <= mul_dataOut[31:0];
            done <= 1'b1;
          end
          state      <= S_IDLE;
          mul_signal <= NOP_CODE;
        end
        default: begin
          state      <= S_IDLE;
          mul_signal <= NOP_CODE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multu_sequencer.sv
// Directed bench for multu_sequencer with a behavioural shift-add multiplier
// that only reloads its operand when its own iteration counter is zero.
module tb_multu_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] opA, opB;
  logic        abort;
  logic        wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic [31:0] mul_dataA, mul_dataB;
  logic [5:0]  mul_signal;
  logic        mul_reset;
  logic [63:0] mul_dataOut;
  logic [31:0] hi, lo;
  logic        busy, done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  multu_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .opA(opA), .opB(opB), .abort(abort), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_data(wr_data), .mul_dataA(mul_dataA), .mul_dataB(mul_dataB),
    .mul_signal(mul_signal), .mul_reset(mul_reset), .mul_dataOut(mul_dataOut),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // multiplier model: P = {0, A}; per iteration add B to the upper half if P[0], shift right
  logic [5:0]  m_cnt;
  logic [63:0] m_p;
  logic [63:0] pv;
  logic [32:0] sum;
  always @(posedge clk or posedge mul_reset) begin
    if (mul_reset) begin
      m_cnt       <= 6'd0;
      m_p         <= 64'd0;
      mul_dataOut <= 64'd0;
    end else begin
      case (mul_signal)
        6'd25: begin
          pv = (m_cnt == 6'd0) ? {32'd0, mul_dataA} : m_p;
          sum = pv[0] ? ({1'b0, pv[63:32]} + {1'b0, mul_dataB}) : {1'b0, pv[63:32]};
          m_p   <= {sum, pv[31:1]};
          m_cnt <= m_cnt + 6'd1;
        end
        6'd63: mul_dataOut <= m_p;
        6'd18: m_cnt <= 6'd0;
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: accept edge happens inside; returns in cycle 1
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    opA = a;
    opB = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("dataA", {32'd0, mul_dataA}, {32'd0, a});
    chk("dataB", {32'd0, mul_dataB}, {32'd0, b});
    chk("busy_c1", {63'd0, busy}, 64'd1);
    chk("ready_c1", {63'd0, req_ready}, 64'd0);
  endtask

  // walks cycles 1..35 of one multiply; optionally holds the next request valid from cycle 34
  task automatic run_op(input logic [63:0] exp, input logic chain,
                        input logic [31:0] na, input logic [31:0] nb);
    logic [63:0] want;
    exp_q.push_back(exp);
    for (int c = 1; c <= 32; c++) begin
      chk($sformatf("mul_sig_c%0d", c), {58'd0, mul_signal}, 64'd25);
      if (c == 1 || c == 32) chk("state_mul", {62'd0, dbg_state}, 64'd1);
      tick();
    end
    chk("out_sig", {58'd0, mul_signal}, 64'd63);
    chk("state_out", {62'd0, dbg_state}, 64'd2);
    tick();
    chk("mflo_sig", {58'd0, mul_signal}, 64'd18);
    chk("done_c34", {63'd0, done}, 64'd0);
    chk("ready_c34", {63'd0, req_ready}, 64'd0);
    if (chain) begin
      opA = na;
      opB = nb;
      req_valid = 1'b1;
    end
    tick();
    chk("done_c35", {63'd0, done}, 64'd1);
    chk("ready_c35", {63'd0, req_ready}, 64'd1);
    chk("busy_c35", {63'd0, busy}, 64'd0);
    chk("nop_sig", {58'd0, mul_signal}, 64'd0);
    want = exp_q.pop_front();
    chk("product", {hi, lo}, want);
    if (chain) begin
      tick();
      req_valid = 1'b0;
      chk("chain_dataA", {32'd0, mul_dataA}, {32'd0, na});
      chk("chain_dataB", {32'd0, mul_dataB}, {32'd0, nb});
      chk("chain_busy", {63'd0, busy}, 64'd1);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    opA = 32'd0;
    opB = 32'd0;
    abort = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wr_data = 32'd0;

    repeat (2) tick();
    chk("rst_mul_reset", {63'd0, mul_reset}, 64'd1);
    reset = 1'b0;
    tick();
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sig", {58'd0, mul_signal}, 64'd0);
    chk("rst_data", {mul_dataA, mul_dataB}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_mul_reset_low", {63'd0, mul_reset}, 64'd0);

    // basic products
    issue(32'd7, 32'd6);
    run_op(64'h00000000_0000002A, 1'b0, 32'd0, 32'd0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(64'hFFFFFFFE_00000001, 1'b0, 32'd0, 32'd0);
    issue(32'h80000000, 32'd2);
    run_op(64'h00000001_00000000, 1'b0, 32'd0, 32'd0);

    // back-to-back with request held valid into the done cycle
    issue(32'd3, 32'd5);
    run_op(64'h00000000_0000000F, 1'b1, 32'h00010000, 32'h00010000);
    run_op(64'h00000001_00000000, 1'b0, 32'd0, 32'd0);

    // abort in cycle 10
    issue(32'h1234, 32'h10);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_clr_sig", {58'd0, mul_signal}, 64'd18);
    chk("abort_clr_state", {62'd0, dbg_state}, 64'd3);
    chk("abort_clr_done", {63'd0, done}, 64'd0);
    tick();
    chk("abort_idle_done", {63'd0, done}, 64'd0);
    chk("abort_idle_ready", {63'd0, req_ready}, 64'd1);
    chk("abort_hilo_kept", {hi, lo}, 64'h00000001_00000000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_idle", {62'd0, dbg_state}, 64'd0);
    issue(32'd9, 32'd9);
    run_op(64'h00000000_00000051, 1'b0, 32'd0, 32'd0);

    // MTHI / MTLO in IDLE
    wr_hi = 1'b1;
    wr_data = 32'hDEAD0000;
    tick();
    wr_hi = 1'b0;
    chk("mthi", {32'd0, hi}, 64'h00000000_DEAD0000);
    chk("mthi_lo_kept", {32'd0, lo}, 64'h00000000_00000051);
    wr_lo = 1'b1;
    wr_data = 32'h0000BEEF;
    tick();
    wr_lo = 1'b0;
    chk("mtlo", {hi, lo}, 64'hDEAD0000_0000BEEF);

    // writes during MUL are ignored, then reset lands in cycle 20
    issue(32'h55, 32'd3);
    repeat (4) tick();
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wr_data = 32'h11111111;
    tick();
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    chk("wr_while_busy", {hi, lo}, 64'hDEAD0000_0000BEEF);
    repeat (14) tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_sig", {58'd0, mul_signal}, 64'd0);
    chk("mid_rst_state", {62'd0, dbg_state}, 64'd0);
    chk("mid_rst_ready_busy", {62'd0, req_ready, busy}, 64'd2);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_data", {mul_dataA, mul_dataB}, 64'd0);
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    chk("mid_rst_mul_reset", {63'd0, mul_reset}, 64'd1);
    tick();
    reset = 1'b0;
    tick();

    // MTLO in the accept cycle, later overwritten by the product
    wr_lo = 1'b1;
    wr_data = 32'h77;
    issue(32'd2, 32'd3);
    wr_lo = 1'b0;
    chk("accept_mtlo", {hi, lo}, 64'h00000000_00000077);
    run_op(64'h00000000_00000006, 1'b0, 32'd0, 32'd0);

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
